// File: rtl/frame_writer.sv
// Pixel sink for the drawer plot stream: clips off-screen pixels, buffers them in a small
// FIFO and issues one linear framebuffer write per cycle; also runs full-screen clear sweeps.
module frame_writer #(
  parameter int WIDTH      = 160,
  parameter int HEIGHT     = 120,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        x_in,
  input  logic [6:0]        y_in,
  input  logic [2:0]        c_in,
  input  logic              plot,
  output logic              ready,
  input  logic              clear,
  input  logic [2:0]        clear_c,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_data,
  output logic              mem_we,
  output logic              dropped,
  output logic              busy,
  output logic [15:0]       pix_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int SWEEP_W = ADDR_W + 1;
  localparam logic [SWEEP_W-1:0] SWEEP_END  = SWEEP_W'(WIDTH * HEIGHT);
  localparam logic [CNT_W-1:0]   FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        colour;
  } pix_t;

  state_e             state_q, state_d;
  pix_t               fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               clear_pending_q, clear_pending_d;
  logic [2:0]         clear_colour_q, clear_colour_d;
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [2:0]         mem_data_q, mem_data_d;
  logic               mem_we_q, mem_we_d;
  logic               clear_done_q, clear_done_d;
  logic               dropped_q, dropped_d;
  logic [15:0]        pix_count_q, pix_count_d;

  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pix_addr;

  assign ready    = (count_q != FIFO_FULL) && !clear_pending_q && (state_q == S_IDLE);
  assign accept   = plot && ready;
  assign in_range = (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
  assign push     = accept && in_range;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  // Linear address is formed at full ADDR_W width before the pixel is buffered.
  assign pix_addr = ADDR_W'(y_in) * ADDR_W'(WIDTH) + ADDR_W'(x_in);

  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign mem_we     = mem_we_q;
  assign clear_done = clear_done_q;
  assign dropped    = dropped_q;
  assign pix_count  = pix_count_q;
  assign busy       = (count_q != '0) | clear_pending_q | (state_q == S_CLEAR) | mem_we_q;

  // NOTE: FIFO storage carries no reset; occupancy is tracked by count_q, which is reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= '{addr: pix_addr, colour: c_in};
    end
  end

  // NOTE: every _d gets a default first so no path through this block infers a latch.
  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    clear_pending_d = clear_pending_q;
    clear_colour_d  = clear_colour_q;
    sweep_d         = sweep_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    mem_we_d        = 1'b0;
    clear_done_d    = 1'b0;
    dropped_d       = accept && !in_range;
    pix_count_d     = pix_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = fifo_mem[rd_ptr_q].addr;
      mem_data_d  = fifo_mem[rd_ptr_q].colour;
      pix_count_d = pix_count_q + 16'd1;
    end

    if (clear && (state_q != S_CLEAR)) begin
      clear_pending_d = 1'b1;
      clear_colour_d  = clear_c;
    end

    case (state_q)
      S_IDLE: begin
        // A clear arriving on the entry edge merges into the sweep that starts now.
        if (clear_pending_q && (count_q == '0)) begin
          state_d         = S_CLEAR;
          clear_pending_d = 1'b0;
          sweep_d         = '0;
        end
      end
      S_CLEAR: begin
        if (sweep_q < SWEEP_END) begin
          mem_we_d   = 1'b1;
          mem_addr_d = sweep_q[ADDR_W-1:0];
          mem_data_d = clear_colour_q;
          sweep_d    = sweep_q + 1'b1;
        end else begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      clear_pending_q <= 1'b0;
      clear_colour_q  <= '0;
      sweep_q         <= '0;
      mem_addr_q      <= '0;
      mem_data_q      <= '0;
      mem_we_q        <= 1'b0;
      clear_done_q    <= 1'b0;
      dropped_q       <= 1'b0;
      pix_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      clear_pending_q <= clear_pending_d;
      clear_colour_q  <= clear_colour_d;
      sweep_q         <= sweep_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_we_q        <= mem_we_d;
      clear_done_q    <= clear_done_d;
      dropped_q       <= dropped_d;
      pix_count_q     <= pix_count_d;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed scenarios plus a randomized plot stream
// scored against a queue-based model of the clip/address/write rules.
module tb_frame_writer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  x_in;
  logic [6:0]  y_in;
  logic [2:0]  c_in;
  logic        plot;
  logic        ready;
  logic        clear;
  logic [2:0]  clear_c;
  logic        clear_done;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        dropped;
  logic        busy;
  logic [15:0] pix_count;

  int tests = 0;
  int fails = 0;

  logic [17:0] wr_q[$];
  int drop_cnt = 0;
  int done_cnt = 0;

  frame_writer dut (
    .clk        (clk),
    .reset      (reset),
    .x_in       (x_in),
    .y_in       (y_in),
    .c_in       (c_in),
    .plot       (plot),
    .ready      (ready),
    .clear      (clear),
    .clear_c    (clear_c),
    .clear_done (clear_done),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .dropped    (dropped),
    .busy       (busy),
    .pix_count  (pix_count)
  );

  always #5 clk = ~clk;

  // Write/pulse recorder, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we) wr_q.push_back({mem_addr, mem_data});
    if (dropped) drop_cnt++;
    if (clear_done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; plot = 1'b0; clear = 1'b0;
    x_in = '0; y_in = '0; c_in = '0; clear_c = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    wr_q.delete();
    drop_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    plot = 1'b1; x_in = 8'd3; y_in = 7'd4; c_in = 3'd1;
    tick(); tick();
    plot = 1'b0;
    reset = 1'b1;
    #1;
    tests++;
    if ({ready, mem_we, clear_done, dropped, busy} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_flags: got rdy/we/done/drop/busy=%b expected 10000",
               {ready, mem_we, clear_done, dropped, busy});
    end
    tests++;
    if ({mem_addr, mem_data, pix_count} !== 34'd0) begin
      fails++;
      $display("FAIL reset_values: got addr=%0d data=%0d pix_count=%0d expected all 0",
               mem_addr, mem_data, pix_count);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pixel();
    do_reset();
    plot = 1'b1; x_in = 8'd10; y_in = 7'd20; c_in = 3'd5;
    tick();
    plot = 1'b0;
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL single_early: got mem_we=%b one edge after accept, expected 0", mem_we);
    end
    tick();
    tests++;
    if ({mem_we, mem_addr, mem_data} !== {1'b1, 15'd3210, 3'd5}) begin
      fails++;
      $display("FAIL single_write: got we=%b addr=%0d data=%0d expected we=1 addr=3210 data=5",
               mem_we, mem_addr, mem_data);
    end
    tests++;
    if (pix_count !== 16'd1) begin
      fails++;
      $display("FAIL single_count: got pix_count=%0d expected 1", pix_count);
    end
    tick();
    tests++;
    if (mem_we !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse: got mem_we=%b in second cycle, expected 0", mem_we);
    end
  endtask

  task automatic test_clipping();
    do_reset();
    plot = 1'b1; x_in = 8'd159; y_in = 7'd119; c_in = 3'd7;
    tick();
    x_in = 8'd160; y_in = 7'd0; c_in = 3'd1;
    tick();
    x_in = 8'd0; y_in = 7'd120; c_in = 3'd1;
    tick();
    plot = 1'b0;
    repeat (4) tick();
    tests++;
    if (wr_q.size() !== 1) begin
      fails++;
      $display("FAIL clip_writes: got %0d writes expected 1", wr_q.size());
    end else if (wr_q[0] !== {15'd19199, 3'd7}) begin
      fails++;
      $display("FAIL clip_writes: got addr=%0d data=%0d expected addr=19199 data=7",
               wr_q[0][17:3], wr_q[0][2:0]);
    end
    tests++;
    if (drop_cnt !== 2) begin
      fails++;
      $display("FAIL clip_dropped: got %0d dropped pulses expected 2", drop_cnt);
    end
    tests++;
    if (pix_count !== 16'd1) begin
      fails++;
      $display("FAIL clip_count: got pix_count=%0d expected 1", pix_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp_w[6];
    int err = 0;
    int rdy_err = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        if (ready !== 1'b1) rdy_err++;
        plot = 1'b1;
        x_in = 8'($urandom_range(0, W - 1));
        y_in = 7'($urandom_range(0, H - 1));
        c_in = 3'($urandom);
        exp_w[i] = {15'(int'(y_in) * W + int'(x_in)), c_in};
      end else begin
        plot = 1'b0;
      end
      if (i >= 2 && i < 8) begin
        if (mem_we !== 1'b1 || {mem_addr, mem_data} !== exp_w[i-2]) err++;
      end else if (mem_we !== 1'b0) begin
        err++;
      end
      tick();
    end
    tests++;
    if (rdy_err !== 0) begin
      fails++;
      $display("FAIL b2b_ready: got ready low in %0d of 6 cycles expected 0", rdy_err);
    end
    tests++;
    if (err !== 0) begin
      fails++;
      $display("FAIL b2b_stream: got %0d bad write cycles expected 0", err);
    end
    tests++;
    if (pix_count !== 16'd6) begin
      fails++;
      $display("FAIL b2b_count: got pix_count=%0d expected 6", pix_count);
    end
  endtask

  task automatic test_clear(input bit with_plot, input logic [2:0] colour);
    int n_exp;
    int err = 0;
    int off;
    bit seen = 0;
    do_reset();
    if (with_plot) begin
      plot = 1'b1; x_in = 8'd1; y_in = 7'd1; c_in = 3'd2;
    end
    clear = 1'b1; clear_c = colour;
    tick();
    plot = 1'b0; clear = 1'b0; clear_c = 3'd0;
    tests++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL clear_ready_low: got ready=%b expected 0", ready);
    end
    for (int i = 0; i < NPIX + 50 && !seen; i++) begin
      tick();
      if (clear_done === 1'b1) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL clear_done_timeout: got no clear_done within %0d cycles", NPIX + 50);
    end else if (ready !== 1'b1) begin
      fails++;
      $display("FAIL clear_done_ready: got ready=%b with clear_done expected 1", ready);
    end
    repeat (3) tick();
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL clear_done_count: got %0d pulses expected 1", done_cnt);
    end
    n_exp = NPIX + (with_plot ? 1 : 0);
    off = with_plot ? 1 : 0;
    tests++;
    if (wr_q.size() !== n_exp) begin
      fails++;
      $display("FAIL clear_write_count: got %0d writes expected %0d", wr_q.size(), n_exp);
    end else begin
      if (with_plot && wr_q[0] !== {15'd161, 3'd2}) err++;
      for (int a = 0; a < NPIX; a++)
        if (wr_q[a + off] !== {15'(a), colour}) err++;
      if (err !== 0) begin
        fails++;
        $display("FAIL clear_sweep: got %0d wrong writes expected 0", err);
      end
    end
    tests++;
    if (pix_count !== 16'(off)) begin
      fails++;
      $display("FAIL clear_count: got pix_count=%0d expected %0d", pix_count, off);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit hit = 0;
    do_reset();
    clear = 1'b1; clear_c = 3'd6;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (mem_we === 1'b1 && mem_addr === 15'd100) hit = 1;
      else tick();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL midsweep_reach: got no write to addr 100 within 300 cycles");
    end
    reset = 1'b1;
    #1;
    done_cnt = 0;
    tests++;
    if ({mem_we, clear_done} !== 2'b00) begin
      fails++;
      $display("FAIL midsweep_abort: got we=%b done=%b expected 0 0", mem_we, clear_done);
    end
    tick(); tick();
    reset = 1'b0;
    repeat (5) tick();
    tests++;
    if ({ready, busy} !== 2'b10 || done_cnt !== 0) begin
      fails++;
      $display("FAIL midsweep_after: got ready=%b busy=%b done_pulses=%0d expected 1 0 0",
               ready, busy, done_cnt);
    end
  endtask

  task automatic test_random_stream();
    logic [17:0] exp_q[$];
    int exp_drops = 0;
    int err = 0;
    bit idle = 0;
    int xi, yi;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      plot = ($urandom_range(0, 9) < 7);
      xi = $urandom_range(0, 179);
      yi = $urandom_range(0, 127);
      x_in = 8'(xi); y_in = 7'(yi); c_in = 3'($urandom);
      if (plot && ready) begin
        if (xi < W && yi < H) exp_q.push_back({15'(yi * W + xi), c_in});
        else exp_drops++;
      end
      tick();
    end
    plot = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      tick();
      if (busy === 1'b0) idle = 1;
    end
    tick();
    tests++;
    if (!idle) begin
      fails++;
      $display("FAIL rand_drain: got busy still high after 30 cycles expected 0");
    end
    tests++;
    if (wr_q.size() !== exp_q.size()) begin
      fails++;
      $display("FAIL rand_writes: got %0d writes expected %0d", wr_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) if (wr_q[k] !== exp_q[k]) err++;
      if (err !== 0) begin
        fails++;
        $display("FAIL rand_contents: got %0d wrong writes expected 0", err);
      end
    end
    tests++;
    if (drop_cnt !== exp_drops) begin
      fails++;
      $display("FAIL rand_dropped: got %0d dropped pulses expected %0d", drop_cnt, exp_drops);
    end
    tests++;
    if (pix_count !== 16'(exp_q.size())) begin
      fails++;
      $display("FAIL rand_count: got pix_count=%0d expected %0d", pix_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_clipping();
    test_back_to_back();
    test_clear(1'b0, 3'd3);
    test_clear(1'b1, 3'd4);
    test_reset_mid_sweep();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
